// File: rtl/dmem_sized.sv
// dmem_sized: word-organised data memory with byte/half/word stores and
// registered, optionally sign-extended loads (one-cycle load latency).
// Optional build macro DMEM_MISALIGN_TRAP_EN: when defined, misaligned
// half/word accesses are rejected with err; otherwise they are aligned down.
module dmem_sized #(
    parameter int ADDR_W    = 10,
    parameter int INIT_ZERO = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic              rvalid,
    output logic              err
);

    localparam int DEPTH = 1 << (ADDR_W - 2);

    // Power-up contents only; reset deliberately leaves the array alone.
    localparam logic [31:0] INIT_WORD = (INIT_ZERO != 0) ? 32'h0000_0000 : 32'hxxxx_xxxx;

    logic [31:0] mem [DEPTH] = '{default: INIT_WORD};

    logic [ADDR_W-3:0] word_idx;
    logic [1:0]        offset;
    logic [1:0]        lane;
    logic [4:0]        shift_amt;
    logic              reject;
    logic [31:0]       rd_word;
    logic [31:0]       rd_shift;
    logic [31:0]       load_val;
    logic [31:0]       wr_data;
    logic [31:0]       wr_mask;
    logic [31:0]       wr_word;

    // Decode the access: pick the starting lane, and decide whether the
    // request is rejected (reserved size, or misaligned when trapping).
    always_comb begin
        word_idx = address[ADDR_W-1:2];
        offset   = address[1:0];
        lane     = offset;
        reject   = 1'b0;
        case (size)
            2'b00:   lane = offset;
            2'b01:   lane = {offset[1], 1'b0};
            2'b10:   lane = 2'b00;
            default: begin
                lane   = offset;
                reject = 1'b1;
            end
        endcase
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((size == 2'b01 && offset[0]) || (size == 2'b10 && offset != 2'b00)) begin
            reject = 1'b1;
        end
`endif
        shift_amt = {lane, 3'b000};
    end

    // Read path: fetch the addressed word, right-align the selected lanes
    // and extend them to 32 bits according to size and sign_ext.
    always_comb begin
        rd_word  = mem[word_idx];
        rd_shift = rd_word >> shift_amt;
        load_val = rd_shift;
        case (size)
            2'b00:   load_val = sign_ext ? {{24{rd_shift[7]}}, rd_shift[7:0]}
                                         : {24'h000000, rd_shift[7:0]};
            2'b01:   load_val = sign_ext ? {{16{rd_shift[15]}}, rd_shift[15:0]}
                                         : {16'h0000, rd_shift[15:0]};
            default: load_val = rd_shift;
        endcase
    end

    // Write path: move right-aligned store data into its lanes and merge it
    // with the untouched lanes of the current word.
    always_comb begin
        case (size)
            2'b00:   wr_mask = 32'h0000_00FF << shift_amt;
            2'b01:   wr_mask = 32'h0000_FFFF << shift_amt;
            2'b10:   wr_mask = 32'hFFFF_FFFF;
            default: wr_mask = 32'h0000_0000;
        endcase
        wr_data = data_in << shift_amt;
        wr_word = (rd_word & ~wr_mask) | (wr_data & wr_mask);
    end

    // Storage update; requests seen while reset is held are dropped.
    always_ff @(posedge clk) begin
        if (rst_n && req && we && !reject) begin
            mem[word_idx] <= wr_word;
        end
    end

    // Response registers: load data, the rvalid pulse and the err pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= 32'h0000_0000;
            rvalid   <= 1'b0;
            err      <= 1'b0;
        end else begin
            rvalid <= req && !we && !reject;
            err    <= req && reject;
            if (req && !we && !reject) begin
                data_out <= load_val;
            end
        end
    end

endmodule
